// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive FIFO and the planned transmit FIFO.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Pointer/level width for a FIFO of the given depth: address bits plus a wrap bit.
  function automatic int fifo_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: low bits address the array, the extra MSB is the wrap bit.
module fifo_ptr
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = fifo_level_w(DEPTH) - 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o,
  output logic          wrap_o
);

  logic [AW:0] ptr_q;
  logic [AW:0] ptr_d;

  // Flush wins over increment; the carry out of the low bits toggles the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o  = ptr_q[AW-1:0];
  assign wrap_o = ptr_q[AW];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the RAM loader,
// with occupancy level and a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W,
  localparam int LW    = fifo_level_w(DEPTH),
  localparam int AW    = LW - 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_data_vld_i,
  output logic              in_data_rdy_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_data_vld_o,
  input  logic              out_data_rdy_i,
  output logic [LW-1:0]     level_o,
  output logic              ovf_o
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both
  // high; ready/valid outputs come only from registers, never from the inputs.

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              ovf_q;
  logic              ovf_d;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_wrap;
  logic          rd_wrap;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .inc_i   (push),
    .ptr_o   (wr_ptr),
    .wrap_o  (wr_wrap)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .inc_i   (pop),
    .ptr_o   (rd_ptr),
    .wrap_o  (rd_wrap)
  );

  assign empty = (wr_ptr == rd_ptr) && (wr_wrap == rd_wrap);
  assign full  = (wr_ptr == rd_ptr) && (wr_wrap != rd_wrap);

  assign in_data_rdy_o  = ~full;
  assign out_data_vld_o = ~empty;
  assign push           = in_data_vld_i & in_data_rdy_o;
  assign pop            = out_data_vld_o & out_data_rdy_i;

  assign out_data_o = mem_q[rd_ptr];
  assign level_o    = {wr_wrap, wr_ptr} - {rd_wrap, rd_ptr};
  assign ovf_o      = ovf_q;

  // A flush leaves the array alone; only the pointers and the flag are cleared.
  always_comb begin
    mem_d = mem_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      ovf_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr] = in_data_i;
      end
      if (in_data_vld_i && full) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule
